// File: rtl/enc164_pkg.sv
// Shared definitions for the 16:4 request-queue encoder.
//   N_LINES  : number of request lines
//   CODE_W   : width of the encoded line index
//   line_t   : one bit per request line
//   code_t   : encoded line index
//   popcount : number of set bits in a line_t (0..N_LINES)
package enc164_pkg;

    localparam int N_LINES = 16;
    localparam int CODE_W  = 4;

    typedef logic [N_LINES-1:0] line_t;
    typedef logic [CODE_W-1:0]  code_t;

    function automatic logic [CODE_W:0] popcount(input line_t v);
        logic [CODE_W:0] c;
        c = '0;
        for (int i = 0; i < N_LINES; i++) begin
            c = c + {{CODE_W{1'b0}}, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/pick_first16.sv
// Combinational rotating first-set-bit finder.
//   mask  in  16  candidate lines
//   start in  4   line index where the search begins (wraps 15 -> 0)
//   found out 1   at least one bit of mask is set
//   idx   out 4   first set line at or after start, in wrap order
// The mask is rotated so that line 'start' lands on bit 0, the lowest set
// bit is found, and the offset is added back to start (4-bit add wraps).
module pick_first16
    import enc164_pkg::*;
(
    input  logic [N_LINES-1:0] mask,
    input  logic [CODE_W-1:0]  start,
    output logic               found,
    output logic [CODE_W-1:0]  idx
);

    logic [2*N_LINES-1:0] dbl;
    line_t                rot;
    code_t                offs;

    assign dbl = {mask, mask} >> start;
    assign rot = dbl[N_LINES-1:0];

    // Scan downwards so the last hit written is the lowest set bit.
    always_comb begin
        found = 1'b0;
        offs  = '0;
        for (int i = N_LINES - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                offs  = code_t'(i);
            end
        end
    end

    assign idx = start + offs;

endmodule

// File: rtl/enc164_req_queue.sv
// Sequential 16:4 encoder: captures request pulses into a pending mask and
// hands out one pending line index per transfer.
//   clk        in   rising-edge clock
//   resetL     in   asynchronous active-low reset
//   enable     in   1: reqIn is captured; 0: reqIn ignored, queue keeps draining
//   flush      in   synchronous clear of pending mask and output register
//   reqIn      in   16 request lines, bit i requests code i
//   outReady   in   consumer accepts outCode this cycle
//   outValid   out  outCode holds a valid, unconsumed code
//   outCode    out  encoded line index
//   pendingCnt out  number of pending lines (0..16)
//   overrun    out  1-cycle pulse: an enabled request hit an already-pending line
//
// Handshake: a code transfers on any rising edge where outValid && outReady.
// Once outValid is high, outCode and outValid stay stable until that transfer;
// the output register reloads (or empties) only when it is empty or being
// consumed on the same edge.
module enc164_req_queue
    import enc164_pkg::*;
#(
    parameter int ROUND_ROBIN = 1
) (
    input  logic               clk,
    input  logic               resetL,
    input  logic               enable,
    input  logic               flush,
    input  logic [N_LINES-1:0] reqIn,
    input  logic               outReady,
    output logic               outValid,
    output logic [CODE_W-1:0]  outCode,
    output logic [CODE_W:0]    pendingCnt,
    output logic               overrun
);

    line_t pending;
    line_t pending_next;
    line_t grant_mask;
    line_t req_gated;
    code_t last_code;
    code_t start;
    code_t sel_idx;
    logic  found;
    logic  load;
    logic  grant;
    logic  overrun_next;

    // Fixed priority is simply a search that always starts at line 0.
    assign start = (ROUND_ROBIN != 0) ? code_t'(last_code + 1'b1) : '0;

    pick_first16 u_pick (
        .mask  (pending),
        .start (start),
        .found (found),
        .idx   (sel_idx)
    );

    assign load       = !outValid || outReady;
    assign grant      = load && found;
    assign grant_mask = grant ? (line_t'(1) << sel_idx) : '0;
    assign req_gated  = enable ? reqIn : '0;

    // A line granted and re-requested on the same edge stays pending.
    assign pending_next = (pending & ~grant_mask) | req_gated;
    assign overrun_next = |(req_gated & pending & ~grant_mask);

    always_ff @(posedge clk or negedge resetL) begin
        if (!resetL) begin
            pending    <= '0;
            outValid   <= 1'b0;
            outCode    <= '0;
            last_code  <= '1;
            pendingCnt <= '0;
            overrun    <= 1'b0;
        end else if (flush) begin
            // last_code is deliberately kept so rotation continues after a flush.
            pending    <= '0;
            outValid   <= 1'b0;
            outCode    <= '0;
            pendingCnt <= '0;
            overrun    <= 1'b0;
        end else begin
            pending    <= pending_next;
            pendingCnt <= popcount(pending_next);
            overrun    <= overrun_next;
            if (load) begin
                if (found) begin
                    outValid  <= 1'b1;
                    outCode   <= sel_idx;
                    last_code <= sel_idx;
                end else begin
                    outValid  <= 1'b0;
                end
            end
        end
    end

endmodule
